// File: rtl/lcd_scanout.sv
// lcd_scanout
//   Reads the 160x144 RGB555 LCD frame buffer and shows it 3x upscaled and
//   centred in the 640x480 VGA raster. One buffer word is fetched per source
//   pixel and held for SCALE output pixels. RGB and the delayed syncs all
//   appear a fixed 3 cycles after the raster inputs that produced them.
//
//   Optional feature macro: LCD_SCANOUT_SCANLINE_EN
//     defined   -> the last sub-row (sub_y == SCALE-1) of every source line is
//                  shown at half intensity inside the window (CRT scanlines).
//     undefined -> all SCALE sub-rows are identical.
//
// Ports
//   Clk, Reset_n         25 MHz pixel clock, asynchronous active-low reset
//   drawX, drawY         current VGA column / row
//   hs_in, vs_in, de_in  syncs and active-video from the VGA controller
//   fb_addr, fb_en       frame buffer read address / one-cycle read enable
//   fb_data              frame buffer read data, valid 1 cycle after fb_en
//   Red, Green, Blue     pixel colour
//   hs_out, vs_out, de_out  sync inputs delayed by 3 cycles
//   frame_start          pulse with the fetch of source pixel (0,0)

module lcd_scanout #(
  parameter int unsigned SCALE  = 3,
  parameter int unsigned LCD_W  = 160,
  parameter int unsigned LCD_H  = 144,
  parameter int unsigned X_OFF  = 80,
  parameter int unsigned Y_OFF  = 24,
  parameter logic [14:0] BORDER = 15'h0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [14:0] fb_addr,
  output logic        fb_en,
  input  logic [14:0] fb_data,
  output logic [4:0]  Red,
  output logic [4:0]  Green,
  output logic [4:0]  Blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        frame_start
);

  localparam int unsigned SX_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned COL_W = $clog2(LCD_W + 1);

  localparam logic [9:0]      C_X_OFF  = 10'(X_OFF);
  localparam logic [9:0]      C_X_END  = 10'(X_OFF + SCALE * LCD_W);
  localparam logic [9:0]      C_X_LAST = 10'(X_OFF + SCALE * LCD_W - 1);
  localparam logic [9:0]      C_Y_OFF  = 10'(Y_OFF);
  localparam logic [9:0]      C_Y_END  = 10'(Y_OFF + SCALE * LCD_H);
  localparam logic [SX_W-1:0] C_SUB_LAST = SX_W'(SCALE - 1);

  // Armed state: after reset the counters are only trusted once the raster
  // has passed through the top of a frame; until then the output is blank.
  typedef enum logic {S_WAIT, S_RUN} state_t;
  state_t r_state;
  state_t w_state_nxt;
  logic   w_frame_top;
  logic   w_armed;

  logic             w_win;
  logic             w_show;
  logic             w_line_start;
  logic [SX_W-1:0]  w_sub_x;
  logic [COL_W-1:0] w_col;
  logic             w_fetch;
  logic [14:0]      w_addr;
  logic             w_sx_wrap;
  logic             w_sy_wrap;
  logic             w_row_adv;

  logic [SX_W-1:0]  r_sub_x;
  logic [COL_W-1:0] r_col;
  logic [SX_W-1:0]  r_sub_y;
  logic [14:0]      r_row_base;

  // Pipeline stage 1 (address issue) and stage 2 (data return)
  logic        r_fb_en;
  logic [14:0] r_fb_addr;
  logic        r_frame_start;
  logic        r_win1, r_show1, r_de1, r_hs1, r_vs1;
  logic        r_fetch2, r_win2, r_show2, r_de2, r_hs2, r_vs2;
`ifdef LCD_SCANOUT_SCANLINE_EN
  logic        r_scan1, r_scan2;
`endif

  // Stage 3 (output)
  logic [14:0] r_hold;
  logic [14:0] r_rgb;
  logic        r_hs3, r_vs3, r_de3;
  logic [14:0] w_pix;
  logic [14:0] w_rgb_nxt;

  assign w_frame_top = vs_in || (drawY < C_Y_OFF);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_WAIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_frame_top) w_state_nxt = S_RUN;
  end

  assign w_armed = (r_state == S_RUN) || w_frame_top;
  assign w_show  = de_in && w_armed;
  assign w_win   = w_show &&
                   (drawX >= C_X_OFF) && (drawX < C_X_END) &&
                   (drawY >= C_Y_OFF) && (drawY < C_Y_END);

  // The first window pixel of a line sees cleared column counters in the
  // same cycle, so fetch timing never depends on the previous line.
  assign w_line_start = w_win && (drawX == C_X_OFF);
  assign w_sub_x      = w_line_start ? '0 : r_sub_x;
  assign w_col        = w_line_start ? '0 : r_col;
  assign w_fetch      = w_win && (w_sub_x == '0);
  assign w_addr       = r_row_base + 15'(w_col);
  assign w_sx_wrap    = (w_sub_x == C_SUB_LAST);
  assign w_sy_wrap    = (r_sub_y == C_SUB_LAST);
  assign w_row_adv    = w_win && (drawX == C_X_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sub_x <= '0;
      r_col   <= '0;
    end else if (w_win) begin
      r_sub_x <= w_sx_wrap ? '0 : w_sub_x + 1'b1;
      r_col   <= w_sx_wrap ? w_col + 1'b1 : w_col;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sub_y    <= '0;
      r_row_base <= '0;
    end else if (w_frame_top) begin
      r_sub_y    <= '0;
      r_row_base <= '0;
    end else if (w_row_adv) begin
      r_sub_y <= w_sy_wrap ? '0 : r_sub_y + 1'b1;
      if (w_sy_wrap) r_row_base <= r_row_base + 15'(LCD_W);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fb_en       <= 1'b0;
      r_fb_addr     <= '0;
      r_frame_start <= 1'b0;
      r_win1        <= 1'b0;
      r_show1       <= 1'b0;
      r_de1         <= 1'b0;
      r_hs1         <= 1'b0;
      r_vs1         <= 1'b0;
      r_fetch2      <= 1'b0;
      r_win2        <= 1'b0;
      r_show2       <= 1'b0;
      r_de2         <= 1'b0;
      r_hs2         <= 1'b0;
      r_vs2         <= 1'b0;
    end else begin
      r_fb_en       <= w_fetch;
      if (w_fetch) r_fb_addr <= w_addr;
      r_frame_start <= w_fetch && (r_row_base == '0) && (r_sub_y == '0) &&
                       (w_col == '0);
      r_win1        <= w_win;
      r_show1       <= w_show;
      r_de1         <= de_in;
      r_hs1         <= hs_in;
      r_vs1         <= vs_in;
      r_fetch2      <= r_fb_en;
      r_win2        <= r_win1;
      r_show2       <= r_show1;
      r_de2         <= r_de1;
      r_hs2         <= r_hs1;
      r_vs2         <= r_vs1;
    end
  end

`ifdef LCD_SCANOUT_SCANLINE_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_scan1 <= 1'b0;
      r_scan2 <= 1'b0;
    end else begin
      r_scan1 <= w_sy_wrap;
      r_scan2 <= r_scan1;
    end
  end
`endif

  // On a fetch cycle the returning word bypasses the hold register so the
  // first of the SCALE output pixels keeps the fixed 3-cycle latency.
  assign w_pix = r_fetch2 ? fb_data : r_hold;

  always_comb begin
    w_rgb_nxt = '0;
    if (r_show2) begin
      if (r_win2) begin
`ifdef LCD_SCANOUT_SCANLINE_EN
        if (r_scan2)
          w_rgb_nxt = {1'b0, w_pix[14:11], 1'b0, w_pix[9:6], 1'b0, w_pix[4:1]};
        else
          w_rgb_nxt = w_pix;
`else
        w_rgb_nxt = w_pix;
`endif
      end else begin
        w_rgb_nxt = BORDER;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hold <= '0;
      r_rgb  <= '0;
      r_hs3  <= 1'b0;
      r_vs3  <= 1'b0;
      r_de3  <= 1'b0;
    end else begin
      if (r_fetch2) r_hold <= fb_data;
      r_rgb <= w_rgb_nxt;
      r_hs3 <= r_hs2;
      r_vs3 <= r_vs2;
      r_de3 <= r_de2;
    end
  end

  assign fb_en       = r_fb_en;
  assign fb_addr     = r_fb_addr;
  assign frame_start = r_frame_start;
  assign Red         = r_rgb[14:10];
  assign Green       = r_rgb[9:5];
  assign Blue        = r_rgb[4:0];
  assign hs_out      = r_hs3;
  assign vs_out      = r_vs3;
  assign de_out      = r_de3;

endmodule

// File: tb/tb_lcd_scanout.sv
// Testbench for lcd_scanout: drives a compressed VGA raster (full scans on
// selected lines, short scans elsewhere) and checks every cycle against a
// reference computed directly from source coordinates.
module tb_lcd_scanout;

  localparam logic [14:0] BORDER_TB = 15'h2A55;
  localparam int NWORDS = 160 * 144;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  drawX = '0;
  logic [9:0]  drawY = '0;
  logic        hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
  logic [14:0] fb_addr;
  logic        fb_en;
  logic [14:0] fb_data = '0;
  logic [4:0]  Red, Green, Blue;
  logic        hs_out, vs_out, de_out, frame_start;

  lcd_scanout #(.BORDER(BORDER_TB)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .drawX(drawX), .drawY(drawY),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .fb_addr(fb_addr), .fb_en(fb_en), .fb_data(fb_data),
    .Red(Red), .Green(Green), .Blue(Blue),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .frame_start(frame_start)
  );

  always #20 Clk = ~Clk;

  logic [14:0] mem [0:NWORDS-1];

  // Synchronous-read frame buffer port
  always @(posedge Clk) if (fb_en) fb_data <= mem[fb_addr];

  typedef struct packed {
    logic        fetch;
    logic [14:0] addr;
    logic        fs;
    logic [14:0] rgb;
    logic        hs, vs, de, chk;
  } exp_t;

  exp_t hist [0:3];
  int   vectors = 0;
  int   miscompares = 0;
  int   ncyc = 0;
  bit   m_armed = 0;
  int   row24_fetches = 0;

  task automatic cyc(input int x, input int y, input bit de, input bit hs,
                     input bit vs, input bit full, input bit rst);
    exp_t e, e3;
    int dx, dy, a;
    logic [14:0] p;
    bit show, win;
    e = '0;
    if (rst) begin
      m_armed = 0;
      e.chk = 1'b1;
    end else begin
      if (vs || y < 24) m_armed = 1;
      show = de && m_armed;
      win  = show && x >= 80 && x < 560 && y >= 24 && y < 456;
      if (win) begin
        dx = x - 80;
        dy = y - 24;
        a  = (dy / 3) * 160 + dx / 3;
        e.fetch = (dx % 3 == 0);
        e.addr  = 15'(a);
        e.fs    = e.fetch && (a == 0) && (y == 24);
        p = mem[a];
`ifdef LCD_SCANOUT_SCANLINE_EN
        if (dy % 3 == 2) p = {1'b0, p[14:11], 1'b0, p[9:6], 1'b0, p[4:1]};
`endif
        e.rgb = p;
      end else if (show) begin
        e.rgb = BORDER_TB;
      end
      e.hs = hs; e.vs = vs; e.de = de; e.chk = full;
    end
    hist[ncyc % 4] = e;

    @(negedge Clk);
    Reset_n = !rst;
    drawX = 10'(x); drawY = 10'(y);
    de_in = de; hs_in = hs; vs_in = vs;
    @(posedge Clk);
    #1;
    vectors++;
    if (y == 24 && fb_en === 1'b1 && !rst) row24_fetches++;

    assert (fb_en === e.fetch) else begin
      miscompares++;
      $error("FAIL fb_en x=%0d y=%0d got %b exp %b", x, y, fb_en, e.fetch);
    end
    if (e.fetch) begin
      assert (fb_addr === e.addr) else begin
        miscompares++;
        $error("FAIL fb_addr x=%0d y=%0d got %0d exp %0d", x, y, fb_addr, e.addr);
      end
    end
    assert (frame_start === e.fs) else begin
      miscompares++;
      $error("FAIL frame_start x=%0d y=%0d got %b exp %b", x, y, frame_start, e.fs);
    end

    if (ncyc >= 2) begin
      e3 = rst ? exp_t'('0) : hist[(ncyc - 2) % 4];
      if (rst) e3.chk = 1'b1;
      assert ({hs_out, vs_out, de_out} === {e3.hs, e3.vs, e3.de}) else begin
        miscompares++;
        $error("FAIL syncs x=%0d y=%0d got %b exp %b", x, y,
               {hs_out, vs_out, de_out}, {e3.hs, e3.vs, e3.de});
      end
      if (e3.chk) begin
        assert ({Red, Green, Blue} === e3.rgb) else begin
          miscompares++;
          $error("FAIL rgb x=%0d y=%0d got %h exp %h", x, y,
                 {Red, Green, Blue}, e3.rgb);
        end
      end
    end
    ncyc++;
  endtask

  task automatic line(input int y, input bit full);
    bit de_row, vs;
    de_row = (y < 480);
    vs = (y == 490 || y == 491);
    if (full) begin
      for (int x = 76; x < 564; x++) cyc(x, y, de_row, 1'b0, vs, 1'b1, 1'b0);
    end else begin
      cyc(0, y, de_row, 1'b0, vs, 1'b0, 1'b0);
      cyc(80, y, de_row, 1'b0, vs, 1'b0, 1'b0);
      cyc(559, y, de_row, 1'b0, vs, 1'b0, 1'b0);
    end
    cyc(640, y, 1'b0, 1'b0, vs, full, 1'b0);
    cyc(656, y, 1'b0, 1'($urandom_range(0, 1)), vs, full, 1'b0);
    cyc(700, y, 1'b0, 1'($urandom_range(0, 1)), vs, full, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = 15'($urandom);
    mem[0] = 15'h7C00;
    mem[1] = 15'h7FFF;

    // Reset held with de toggling: outputs stay cleared
    for (int i = 0; i < 8; i++) cyc(600 + i, 0, 1'(i % 2), 1'(i % 3 == 0), 1'b0, 1'b1, 1'b1);
    assert (fb_addr === 15'd0) else begin
      miscompares++;
      $error("FAIL reset_addr got %0d exp 0", fb_addr);
    end

    // Frame 1: released at drawY=0
    for (int y = 0; y < 525; y++) begin
      line(y, (y >= 24 && y <= 27) || y == 100 || y == 454 || y == 455 ||
              y == 456 || y == 470 ||
              (y > 27 && y < 454 && $urandom_range(0, 29) == 0));
      if (y == 24) begin
        assert (row24_fetches === 160) else begin
          miscompares++;
          $error("FAIL row24_fetch_count got %0d exp 160", row24_fetches);
        end
      end
    end

    // Frame 2: reset in the middle of row 31, output blank until next frame
    for (int y = 0; y < 31; y++) line(y, y == 24 || y == 30);
    for (int x = 76; x < 300; x++) cyc(x, 31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int x = 300; x < 303; x++) cyc(x, 31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int x = 303; x < 564; x++) cyc(x, 31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(656, 31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int y = 32; y < 525; y++) line(y, y == 32 || y == 200);

    // Frame 3: scanout restarts at address 0
    for (int y = 0; y < 28; y++) line(y, y >= 24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
